// File: rtl/pcecd_cmd_collector.sv
// pcecd_cmd_collector
//
// Collects a SCSI command descriptor block (CDB) from the initiator during the
// COMMAND phase. It uses a REQ/ACK handshake with one byte per handshake. The
// CDB length comes from the opcode group in byte 0:
//   group 0       -> 6 bytes
//   groups 1,2,6,7 -> 10 bytes
//   groups 3,4,5  -> illegal; only byte 0 is captured and o_cmd_error is set
// The finished CDB is presented with o_cdb_valid and held until i_cdb_ack.
//
// Optional feature (macro PCECD_CMDBUF_TIMEOUT_EN):
//   A per-byte watchdog. If the handshake stalls for TIMEOUT_CYCLES cycles in
//   REQ_HI or ACK_LO, the command is aborted and o_timeout pulses for one
//   cycle. In the default build (macro undefined) o_timeout is tied to 0 and
//   the FSM waits indefinitely.
//
// Ports:
//   i_clk        sole clock, posedge
//   i_RESET_N    synchronous active-low reset
//   i_bus_rst    initiator bus RST; same effect as reset, highest priority
//   i_phase_cmd  target is in COMMAND phase
//   i_DB[7:0]    initiator data byte
//   i_ACK        initiator ACK level
//   o_REQ        target REQ for the next command byte
//   o_cdb[79:0]  collected CDB; byte n at [8n+7:8n]; unused bytes read 0
//   o_cdb_len    bytes collected (1, 6 or 10 when valid)
//   o_cdb_valid  CDB complete, held until i_cdb_ack
//   i_cdb_ack    consumer has taken the CDB
//   o_cmd_error  illegal opcode group; qualifies o_cdb_valid
//   o_timeout    one-cycle pulse on byte timeout
module pcecd_cmd_collector #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clk,
    input  logic        i_RESET_N,
    input  logic        i_bus_rst,
    input  logic        i_phase_cmd,
    input  logic [7:0]  i_DB,
    input  logic        i_ACK,
    output logic        o_REQ,
    output logic [79:0] o_cdb,
    output logic [3:0]  o_cdb_len,
    output logic        o_cdb_valid,
    input  logic        i_cdb_ack,
    output logic        o_cmd_error,
    output logic        o_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        REQ_HI,
        ACK_LO,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [79:0] cdb_q, cdb_d;
    logic [3:0]  count_q, count_d;
    logic [3:0]  target_len;
    logic        illegal_op;
    logic        soft_rst;

    assign soft_rst = !i_RESET_N || i_bus_rst;

    // Byte 0 is only read in ACK_LO and DONE, where it has already been stored.
    always_comb begin
        target_len = 4'd1;
        illegal_op = 1'b0;
        unique case (cdb_q[7:5])
            3'd0:                   target_len = 4'd6;
            3'd1, 3'd2, 3'd6, 3'd7: target_len = 4'd10;
            default: begin
                target_len = 4'd1;
                illegal_op = 1'b1;
            end
        endcase
    end

`ifdef PCECD_CMDBUF_TIMEOUT_EN
    localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               waiting;
    logic               expired;
    logic               timeout_q;

    assign waiting = (state_q == REQ_HI) || (state_q == ACK_LO);
    // The timer is zero on the first cycle in a wait state, so hitting N-1
    // means N cycles have elapsed.
    assign expired = waiting && (timer_q == TIMER_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d = state_q;
        cdb_d   = cdb_q;
        count_d = count_q;

        unique case (state_q)
            IDLE: begin
                if (i_phase_cmd) begin
                    cdb_d   = '0;
                    count_d = '0;
                    state_d = REQ_HI;
                end
            end
            REQ_HI: begin
                if (!i_phase_cmd) begin
                    count_d = '0;
                    state_d = IDLE;
                end else if (i_ACK) begin
                    // The count never reaches 10 here. The guard keeps a
                    // stray write from landing outside the CDB.
                    for (int n = 0; n < 10; n++) begin
                        if (count_q == 4'(n)) begin
                            cdb_d[8*n +: 8] = i_DB;
                        end
                    end
                    if (count_q < 4'd10) begin
                        count_d = count_q + 4'd1;
                    end
                    state_d = ACK_LO;
                end
            end
            ACK_LO: begin
                if (!i_phase_cmd) begin
                    count_d = '0;
                    state_d = IDLE;
                end else if (!i_ACK) begin
                    state_d = (count_q >= target_len) ? DONE : REQ_HI;
                end
            end
            DONE: begin
                if (i_cdb_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef PCECD_CMDBUF_TIMEOUT_EN
        if (expired) begin
            count_d = '0;
            state_d = IDLE;
        end
        // Clear on every state change, including an accepted byte
        // (REQ_HI -> ACK_LO).
        timer_d = (waiting && (state_d == state_q)) ? timer_q + TIMER_W'(1) : '0;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (soft_rst) begin
            state_q <= IDLE;
            cdb_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cdb_q   <= cdb_d;
            count_q <= count_d;
        end
    end

`ifdef PCECD_CMDBUF_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (soft_rst) begin
            timer_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timer_q   <= timer_d;
            timeout_q <= expired;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_REQ       = (state_q == REQ_HI);
    assign o_cdb_valid = (state_q == DONE);
    assign o_cmd_error = (state_q == DONE) && illegal_op;
    assign o_cdb       = cdb_q;
    assign o_cdb_len   = count_q;

endmodule

// File: tb/tb_pcecd_cmd_collector.sv
// Directed testbench for pcecd_cmd_collector. It uses a scoreboard queue of
// expected CDBs.
module tb_pcecd_cmd_collector;

    logic        i_clk = 1'b0;
    logic        i_RESET_N;
    logic        i_bus_rst;
    logic        i_phase_cmd;
    logic [7:0]  i_DB;
    logic        i_ACK;
    logic        o_REQ;
    logic [79:0] o_cdb;
    logic [3:0]  o_cdb_len;
    logic        o_cdb_valid;
    logic        i_cdb_ack;
    logic        o_cmd_error;
    logic        o_timeout;

    pcecd_cmd_collector #(
        .TIMEOUT_CYCLES(16)
    ) dut (
        .i_clk       (i_clk),
        .i_RESET_N   (i_RESET_N),
        .i_bus_rst   (i_bus_rst),
        .i_phase_cmd (i_phase_cmd),
        .i_DB        (i_DB),
        .i_ACK       (i_ACK),
        .o_REQ       (o_REQ),
        .o_cdb       (o_cdb),
        .o_cdb_len   (o_cdb_len),
        .o_cdb_valid (o_cdb_valid),
        .i_cdb_ack   (i_cdb_ack),
        .o_cmd_error (o_cmd_error),
        .o_timeout   (o_timeout)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [3:0]  len;
        logic        err;
        logic [79:0] cdb;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Count REQ rising edges from posedge samples.
    int   req_rises = 0;
    logic req_prev  = 1'b0;
    always @(posedge i_clk) begin
        req_prev <= o_REQ;
        if (o_REQ === 1'b1 && req_prev !== 1'b1) req_rises <= req_rises + 1;
    end

    int rises_base;

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"}, 80'(o_REQ), 80'd0);
        check({tag, "_cdb"}, o_cdb, 80'd0);
        check({tag, "_len"}, 80'(o_cdb_len), 80'd0);
        check({tag, "_valid"}, 80'(o_cdb_valid), 80'd0);
        check({tag, "_err"}, 80'(o_cmd_error), 80'd0);
        check({tag, "_tmo"}, 80'(o_timeout), 80'd0);
    endtask

    // Independent model of length/error/capture from the byte list.
    task automatic push_expected(input logic [79:0] bytes);
        exp_t e;
        logic [2:0] g;
        g = bytes[7:5];
        if (g == 3'd0) begin
            e.len = 4'd6;
            e.err = 1'b0;
        end else if (g == 3'd3 || g == 3'd4 || g == 3'd5) begin
            e.len = 4'd1;
            e.err = 1'b1;
        end else begin
            e.len = 4'd10;
            e.err = 1'b0;
        end
        e.cdb = '0;
        for (int i = 0; i < 10; i++) begin
            if (i < int'(e.len)) e.cdb[8*i +: 8] = bytes[8*i +: 8];
        end
        sb.push_back(e);
    endtask

    task automatic wait_req_high();
        int k = 0;
        while (o_REQ !== 1'b1 && k < 40) begin
            @(negedge i_clk);
            k++;
        end
        if (o_REQ !== 1'b1) check("req_wait", 80'(o_REQ), 80'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int k = 0;
        wait_req_high();
        i_DB  = b;
        i_ACK = 1'b1;
        @(negedge i_clk);
        while (o_REQ !== 1'b0 && k < 40) begin
            @(negedge i_clk);
            k++;
        end
        if (o_REQ !== 1'b0) check("req_drop_wait", 80'(o_REQ), 80'd0);
        i_ACK = 1'b0;
        i_DB  = 8'h00;
    endtask

    task automatic send_cmd(input logic [79:0] bytes, input int n);
        rises_base  = req_rises;
        i_phase_cmd = 1'b1;
        for (int i = 0; i < n; i++) send_byte(bytes[8*i +: 8]);
    endtask

    task automatic wait_and_compare(input string tag);
        int   k = 0;
        exp_t e;
        while (o_cdb_valid !== 1'b1 && k < 20) begin
            @(negedge i_clk);
            k++;
        end
        check({tag, "_valid"}, 80'(o_cdb_valid), 80'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 80'd0, 80'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_len"}, 80'(o_cdb_len), 80'(e.len));
            check({tag, "_err"}, 80'(o_cmd_error), 80'(e.err));
            check({tag, "_cdb"}, o_cdb, e.cdb);
            check({tag, "_req"}, 80'(o_REQ), 80'd0);
            check({tag, "_req_pulses"}, 80'(req_rises - rises_base), 80'(e.len));
        end
    endtask

    task automatic consume(input string tag);
        logic held = 1'b1;
        int   r0   = req_rises;
        // i_phase_cmd is still high here and must be ignored in DONE.
        repeat (3) begin
            @(negedge i_clk);
            held &= (o_cdb_valid === 1'b1) && (o_REQ === 1'b0);
        end
        check({tag, "_hold"}, 80'(held), 80'd1);
        check({tag, "_no_more_req"}, 80'(req_rises - r0), 80'd0);
        i_phase_cmd = 1'b0;
        i_cdb_ack   = 1'b1;
        @(negedge i_clk);
        i_cdb_ack = 1'b0;
        check({tag, "_ack_valid"}, 80'(o_cdb_valid), 80'd0);
        check({tag, "_ack_err"}, 80'(o_cmd_error), 80'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [79:0] b;
        int          at;
        int          pulses;
        logic        req_at16;
        logic        tmo_seen;
        logic        req_stuck;

        i_RESET_N   = 1'b0;
        i_bus_rst   = 1'b0;
        i_phase_cmd = 1'b0;
        i_DB        = 8'h00;
        i_ACK       = 1'b0;
        i_cdb_ack   = 1'b0;
        repeat (3) @(negedge i_clk);
        check_reset_outputs("reset");
        i_RESET_N = 1'b1;
        @(negedge i_clk);

        // Six-byte command of all zeros.
        b = '0;
        push_expected(b);
        send_cmd(b, 6);
        wait_and_compare("zero6");
        consume("zero6");
        @(negedge i_clk);

        // Ten-byte group-6 command.
        b = 80'h09_08_07_06_05_04_03_02_01_D8;
        push_expected(b);
        send_cmd(b, 10);
        wait_and_compare("grp6");
        check("grp6_byte0", 80'(o_cdb[7:0]), 80'hD8);
        check("grp6_byte9", 80'(o_cdb[79:72]), 80'h09);
        consume("grp6");
        @(negedge i_clk);

        // Illegal group 3.
        b = 80'h60;
        push_expected(b);
        send_cmd(b, 1);
        wait_and_compare("illegal");
        consume("illegal");
        @(negedge i_clk);

        // Abort after byte 3 of a six-byte command.
        send_cmd(80'hAA_BB_CC_33_22_08, 3);
        wait_req_high();
        i_phase_cmd = 1'b0;
        @(negedge i_clk);
        check("abort_req", 80'(o_REQ), 80'd0);
        repeat (4) @(negedge i_clk);
        check("abort_valid", 80'(o_cdb_valid), 80'd0);
        b = 80'h65_54_43_32_21_10;
        push_expected(b);
        send_cmd(b, 6);
        wait_and_compare("after_abort");
        consume("after_abort");
        @(negedge i_clk);

        // Timeout: REQ high with ACK held low.
        i_phase_cmd = 1'b1;
        wait_req_high();
`ifdef PCECD_CMDBUF_TIMEOUT_EN
        at       = -1;
        pulses   = 0;
        req_at16 = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge i_clk);
            if (o_timeout === 1'b1) begin
                pulses++;
                if (at < 0) at = k;
            end
            if (k == 16) req_at16 = o_REQ;
        end
        check("timeout_cycle", 80'(at), 80'd16);
        check("timeout_pulses", 80'(pulses), 80'd1);
        check("timeout_req_low", 80'(req_at16), 80'd0);
`else
        tmo_seen  = 1'b0;
        req_stuck = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge i_clk);
            tmo_seen  |= (o_timeout !== 1'b0);
            req_stuck &= (o_REQ === 1'b1);
        end
        check("no_timeout", 80'(tmo_seen), 80'd0);
        check("req_waits", 80'(req_stuck), 80'd1);
`endif
        i_phase_cmd = 1'b0;
        repeat (2) @(negedge i_clk);

        // Reset after byte 2.
        send_cmd(80'h77_66_55_44_33_22_11_00_5A_28, 2);
        wait_req_high();
        i_RESET_N = 1'b0;
        @(negedge i_clk);
        check_reset_outputs("mid_reset");
        i_RESET_N   = 1'b1;
        i_phase_cmd = 1'b0;
        repeat (2) @(negedge i_clk);
        check("mid_reset_no_valid", 80'(o_cdb_valid), 80'd0);

        // Bus reset while in DONE.
        b = 80'h99_88_77_66_55_44_33_22_11_28;
        push_expected(b);
        send_cmd(b, 10);
        wait_and_compare("busrst");
        i_bus_rst = 1'b1;
        @(negedge i_clk);
        check_reset_outputs("busrst");
        i_bus_rst   = 1'b0;
        i_phase_cmd = 1'b0;
        repeat (2) @(negedge i_clk);
        check("busrst_no_valid", 80'(o_cdb_valid), 80'd0);
        check("sb_drained", 80'(sb.size()), 80'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pcecd_cmd_collector.md
PCECD_CMD_COLLECTOR -- requirements
Module: pcecd_cmd_collector

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the max cycles waiting on ACK per byte before abort (used only with PCECD_CMDBUF_TIMEOUT_EN).
REQ-002 SHALL have port i_clk  input  1  sole clock; all logic on posedge.
REQ-003 SHALL have port i_RESET_N  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port i_bus_rst  input  1  initiator RST signal; synchronous abort.
REQ-005 SHALL have port i_phase_cmd  input  1  target is in COMMAND phase.
REQ-006 SHALL have port i_DB  input  8  initiator data bus byte.
REQ-007 SHALL have port i_ACK  input  1  initiator ACK level.
REQ-008 SHALL have port o_REQ  output  1  target REQ for the next command byte.
REQ-009 SHALL have port o_cdb  output  80  collected CDB; byte n at bits [8n+7:8n].
REQ-010 SHALL have port o_cdb_len  output  4  bytes collected (1, 6 or 10).
REQ-011 SHALL have port o_cdb_valid  output  1  CDB complete; held until consumed.
REQ-012 SHALL have port i_cdb_ack  input  1  consumer has taken the CDB.
REQ-013 SHALL have port o_cmd_error  output  1  illegal opcode group; qualifies o_cdb_valid.
REQ-014 SHALL have port o_timeout  output  1  one-cycle pulse on byte timeout.

Function
REQ-015 SHALL implement FSM states IDLE, REQ_HI, ACK_LO, DONE.
REQ-016 SHALL, in IDLE with i_phase_cmd=1, clear o_cdb and the byte count and go to REQ_HI, with o_REQ=1 on the next cycle.
REQ-017 SHALL, in REQ_HI with i_ACK=1 sampled, write i_DB to byte[count] and increment count, then drop o_REQ and enter ACK_LO on the next cycle.
REQ-018 SHALL derive length from byte 0 bits[7:5]: group 0 gives 6; groups 1 and 2 give 10; groups 6 and 7 give 10; groups 3, 4 and 5 are illegal with length 1.
REQ-019 SHALL, in ACK_LO with i_ACK=0, enter DONE if count equals length; otherwise enter REQ_HI, with o_REQ rising one cycle after i_ACK=0 is sampled.
REQ-020 SHALL, in DONE, hold o_cdb_valid=1 plus stable o_cdb, o_cdb_len and o_cmd_error, with o_REQ=0.
REQ-021 SHALL, in DONE with i_cdb_ack=1, clear o_cdb_valid and o_cmd_error next cycle, return to IDLE and ignore i_phase_cmd that cycle.
REQ-022 SHALL assert o_cmd_error together with o_cdb_valid on an illegal opcode, with o_cdb_len=1 and only byte 0 captured.
REQ-023 SHALL, on i_phase_cmd=0 in REQ_HI or ACK_LO, abort to IDLE, clear o_REQ and count, and never assert o_cdb_valid for that command.
REQ-024 SHALL ignore i_phase_cmd and i_ACK while in DONE.
REQ-025 SHALL cap count at 10; bytes beyond length are never written, and unused o_cdb bytes read 0.
REQ-026 SHALL give i_bus_rst priority over all FSM actions, with the same effect as reset.

Reset
REQ-027 SHALL, while i_RESET_N=0 at a clock edge, set state IDLE, o_REQ=0, o_cdb=0, o_cdb_len=0, o_cdb_valid=0, o_cmd_error=0, o_timeout=0 and timeout counter=0.
REQ-028 SHALL, when reset occurs mid-command or in DONE, discard the partial or pending CDB without any valid pulse.

Configuration
REQ-029 SHALL, with PCECD_CMDBUF_TIMEOUT_EN defined: clear a cycle counter on entry to REQ_HI or ACK_LO and on each accepted byte; when it reaches TIMEOUT_CYCLES in either state, abort as in REQ-023 and pulse o_timeout high for exactly one cycle.
REQ-030 SHALL, without PCECD_CMDBUF_TIMEOUT_EN: have no counter logic, tie o_timeout to 0, and leave the FSM waiting on ACK indefinitely.

Verification
REQ-031 SHALL cover: bytes 00 00 00 00 00 00 via REQ/ACK -> o_cdb_valid=1, o_cdb_len=6, o_cdb=0, o_cmd_error=0, o_REQ=0 until i_cdb_ack.
REQ-032 SHALL cover: bytes D8 01 02 03 04 05 06 07 08 09 -> o_cdb_len=10, o_cdb[7:0]=D8, o_cdb[79:72]=09, exactly 10 REQ pulses.
REQ-033 SHALL cover: byte 0x60 -> after one byte o_cdb_valid=1, o_cmd_error=1, o_cdb_len=1, no further REQ.
REQ-034 SHALL cover: drop i_phase_cmd after byte 3 of a 6-byte command -> o_REQ=0 next cycle, no o_cdb_valid, next command starts from byte 0.
REQ-035 SHALL cover, with macro defined and TIMEOUT_CYCLES=16: hold i_ACK=0 with REQ high -> one o_timeout pulse 16 cycles after REQ rise, state IDLE; without macro o_timeout stays 0.
REQ-036 SHALL cover: i_RESET_N=0 for one cycle after byte 2, and separately i_bus_rst=1 in DONE -> all outputs at reset values next cycle.
